tt_sweep: RTL and testbench

- Sequential "reader" for a 4-input combinational logic function under test (SOP/POS style gate network, inputs a,b,c,d, output f_s).
- Drives all 16 input combinations in minterm order and samples the function output after a settle interval.
- Assembles the 16-bit truth table, counts minterms and compares against an expected table.
- Sits beside the gate-level function blocks as an on-chip checker / lab-board self-test driver.

---
 rtl/tt_pkg.sv | 15 +
 rtl/tt_popcount.sv | 18 +
 rtl/tt_sweep.sv | 130 +++++++++++++
 tb/tb_tt_sweep.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared constants and state encoding for the truth-table sweep tools.
// Four-input functions give sixteen minterms; counts need five bits.
package tt_pkg;
  localparam int NUM_VARS     = 4;
  localparam int NUM_MINTERMS = 16;
  localparam int IDX_W        = 4;
  localparam int CNT_W        = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;
endpackage

// File: rtl/tt_popcount.sv
// Combinational popcount of a 16-entry truth table.
// Five-bit result so an all-ones table reads 16.
module tt_popcount
  import tt_pkg::*;
(
  input  logic [NUM_MINTERMS-1:0] vec_i,
  output logic [CNT_W-1:0]        count_o
);

  // Sum the set bits of the table.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_MINTERMS; i++) begin
      count_o = count_o + CNT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/tt_sweep.sv
// Steps a 4-input function through all minterms, samples f_s,
// and publishes the truth table, its popcount and a match flag.
module tt_sweep
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_MINTERMS-1:0] expected,
  input  logic                    f_s,
  output logic                    a,
  output logic                    b,
  output logic                    c,
  output logic                    d,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_MINTERMS-1:0] tt,
  output logic [CNT_W-1:0]        minterm_count,
  output logic                    match
);

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES);
  localparam state_t     HOLD_ST =
    (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_WAIT;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [NUM_MINTERMS-1:0] shadow_q, shadow_d;
  logic [NUM_MINTERMS-1:0] exp_q, exp_d;
  logic [NUM_MINTERMS-1:0] tt_q, tt_d;
  logic [CNT_W-1:0]        mcnt_q, mcnt_d;
  logic                    match_q, match_d;
  logic [NUM_MINTERMS-1:0] shadow_nx;
  logic [CNT_W-1:0]        pc;

  tt_popcount u_pc (
    .vec_i   (shadow_nx),
    .count_o (pc)
  );

  // Shadow table with the current sample merged in.
  always_comb begin
    shadow_nx        = shadow_q;
    shadow_nx[idx_q] = f_s;
  end

  // Sweep sequencing; results commit only on DONE entry.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    exp_d    = exp_q;
    tt_d     = tt_q;
    mcnt_d   = mcnt_q;
    match_d  = match_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (start) begin
          idx_d    = '0;
          exp_d    = expected;
          shadow_d = '0;
          cnt_d    = RELOAD;
          state_d  = HOLD_ST;
        end
      end
      (state_q == ST_WAIT): begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_SAMPLE;
        end
      end
      (state_q == ST_SAMPLE): begin
        shadow_d = shadow_nx;
        if (idx_q == 4'd15) begin
          idx_d   = '0;
          tt_d    = shadow_nx;
          mcnt_d  = pc;
          match_d = (shadow_nx == exp_q);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = RELOAD;
          state_d = HOLD_ST;
        end
      end
      (state_q == ST_DONE): begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      exp_q    <= '0;
      tt_q     <= '0;
      mcnt_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
      tt_q     <= tt_d;
      mcnt_q   <= mcnt_d;
      match_q  <= match_d;
    end
  end

  assign {a, b, c, d}  = idx_q;
  assign busy          = (state_q == ST_WAIT) ||
                         (state_q == ST_SAMPLE);
  assign done          = (state_q == ST_DONE);
  assign tt            = tt_q;
  assign minterm_count = mcnt_q;
  assign match         = match_q;

endmodule

// File: tb/tb_tt_sweep.sv
// Scoreboard bench for tt_sweep: two instances (settle 1 and 0)
// against a truth-table model of the function under test.
module tb_tt_sweep;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic        m;
    int          when;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       start_r = '0;
  logic [1:0][15:0] exp_in = '0;
  logic [1:0][15:0] ftab = '0;

  wire  [1:0][3:0]  vec;
  wire  [1:0]       fs;
  wire  [1:0]       busy_w;
  wire  [1:0]       done_w;
  wire  [1:0][15:0] tt_w;
  wire  [1:0][4:0]  cnt_w;
  wire  [1:0]       match_w;

  int   cyc = 0;
  bit   rst_e = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  int   s_cyc[2] = '{1, 0};
  int   len[2]   = '{32, 16};
  int   k0[2]    = '{0, 0};
  bit   act[2]   = '{1'b0, 1'b0};
  logic [15:0] pub_tt[2] = '{16'h0, 16'h0};
  logic        pub_m[2]  = '{1'b0, 1'b0};
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;

  assign fs[0] = ftab[0][vec[0]];
  assign fs[1] = ftab[1][vec[1]];

  tt_sweep #(.SETTLE_CYCLES(1)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .start         (start_r[0]),
    .expected      (exp_in[0]),
    .f_s           (fs[0]),
    .a             (vec[0][3]),
    .b             (vec[0][2]),
    .c             (vec[0][1]),
    .d             (vec[0][0]),
    .busy          (busy_w[0]),
    .done          (done_w[0]),
    .tt            (tt_w[0]),
    .minterm_count (cnt_w[0]),
    .match         (match_w[0])
  );

  tt_sweep #(.SETTLE_CYCLES(0)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .start         (start_r[1]),
    .expected      (exp_in[1]),
    .f_s           (fs[1]),
    .a             (vec[1][3]),
    .b             (vec[1][2]),
    .c             (vec[1][1]),
    .d             (vec[1][0]),
    .busy          (busy_w[1]),
    .done          (done_w[1]),
    .tt            (tt_w[1]),
    .minterm_count (cnt_w[1]),
    .match         (match_w[1])
  );

  always @(posedge clk) begin
    cyc   = cyc + 1;
    rst_e = rst;
  end

  task automatic chk(input int u, input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h",
               nm, u, cyc, got, want);
    end
  endtask

  function automatic int sb_size(input int u);
    return (u == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic sb_push(input int u, input exp_t e);
    if (u == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic sb_pop(input int u, output exp_t e);
    if (u == 0) e = sb0.pop_front();
    else e = sb1.pop_front();
  endtask

  task automatic mon(input int u);
    exp_t e;
    bit   sweeping;
    int   ix;
    if (rst_e) begin
      sb0.delete();
      sb1.delete();
      act[0] = 1'b0;
      act[1] = 1'b0;
      pub_tt[u] = '0;
      pub_m[u]  = 1'b0;
      chk(u, "rst_done", 32'(done_w[u]), 0);
    end
    sweeping = act[u] && cyc >= k0[u] && cyc < k0[u] + len[u];
    if (sweeping) begin
      ix = (cyc - k0[u]) / (s_cyc[u] + 1);
      chk(u, "busy_sweep", 32'(busy_w[u]), 1);
      chk(u, "vector", 32'(vec[u]), 32'(ix));
      if (done_w[u]) chk(u, "early_done", 1, 0);
    end else if (done_w[u]) begin
      if (sb_size(u) == 0) begin
        chk(u, "unexpected_done", 1, 0);
      end else begin
        sb_pop(u, e);
        chk(u, "done_latency", 32'(cyc), 32'(e.when));
        chk(u, "tt", 32'(tt_w[u]), 32'(e.tt));
        chk(u, "count", 32'(cnt_w[u]), 32'(e.cnt));
        chk(u, "match", 32'(match_w[u]), 32'(e.m));
        pub_tt[u] = e.tt;
        pub_m[u]  = e.m;
        act[u]    = 1'b0;
      end
      chk(u, "busy_done", 32'(busy_w[u]), 0);
      chk(u, "vector_done", 32'(vec[u]), 0);
    end else begin
      chk(u, "busy_idle", 32'(busy_w[u]), 0);
      chk(u, "vector_idle", 32'(vec[u]), 0);
      if (act[u] && cyc >= k0[u] + len[u]) begin
        chk(u, "missing_done", 0, 1);
        sb_pop(u, e);
        act[u] = 1'b0;
      end
    end
    if (!done_w[u]) begin
      chk(u, "tt_hold", 32'(tt_w[u]), 32'(pub_tt[u]));
      chk(u, "count_hold", 32'(cnt_w[u]),
          32'($countones(pub_tt[u])));
      chk(u, "match_hold", 32'(match_w[u]), 32'(pub_m[u]));
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) mon(u);
  end

  task automatic pulse(input logic [1:0] m);
    exp_t e;
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      if (m[u]) begin
        start_r[u] = 1'b1;
        if (!act[u] && !rst) begin
          act[u] = 1'b1;
          k0[u]  = cyc + 1;
          e.tt   = ftab[u];
          e.cnt  = 5'($countones(ftab[u]));
          e.m    = (ftab[u] == exp_in[u]);
          e.when = k0[u] + len[u];
          sb_push(u, e);
        end
      end
    end
    @(posedge clk);
    #1;
    start_r = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!act[0] && !act[1]) break;
      @(posedge clk);
    end
    if (act[0] || act[1]) begin
      chk(0, "sweep_timeout", 1, 0);
      act[0] = 1'b0;
      act[1] = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    bit          hit;
    do_reset(2);

    ftab[0] = 16'hC4F4; exp_in[0] = 16'hC4F4;
    ftab[1] = 16'hFFFF; exp_in[1] = 16'hFFFF;
    pulse(2'b11);
    wait_idle();

    ftab[1] = 16'h0000; exp_in[1] = 16'h0000;
    exp_in[0] = 16'hC4F5;
    pulse(2'b11);
    exp_in[0] = 16'hC4F4;
    exp_in[1] = 16'h1234;
    wait_idle();

    ftab[0] = 16'h5A3C; exp_in[0] = 16'h5A3C;
    pulse(2'b01);
    repeat (3) @(posedge clk);
    pulse(2'b01);
    repeat (13) @(posedge clk);
    pulse(2'b01);
    wait_idle();

    for (int k = 0; k < 6; k++) begin
      for (int u = 0; u < 2; u++) begin
        r = 16'($urandom);
        ftab[u] = r;
        if ($urandom_range(0, 1) == 1) exp_in[u] = r;
        else exp_in[u] = r ^ (16'h1 << $urandom_range(0, 15));
      end
      pulse(2'b11);
      wait_idle();
    end

    ftab[0] = 16'h9E61; exp_in[0] = 16'h9E61;
    pulse(2'b01);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vec[0] == 4'd9) begin
        hit = 1'b1;
        break;
      end
    end
    chk(0, "reach_index9", 32'(hit), 1);
    do_reset(1);
    repeat (40) @(posedge clk);
    pulse(2'b01);
    wait_idle();

    @(posedge clk);
    #1;
    rst = 1'b1;
    start_r = 2'b11;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_r = '0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
